// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack op encodings, selector codes and the
// stack sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] SEL_NONE = 4'h0;
  localparam logic [3:0] OP_PUSH  = 4'h1;
  localparam logic [3:0] OP_POP   = 4'h2;
  localparam logic [3:0] OP_CALL  = 4'h3;
  localparam logic [3:0] OP_RET   = 4'h4;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_t;

endpackage

// File: rtl/stack_op_sequencer.sv
// Multi-cycle stack sequencer: runs PUSH/POP/CALL/RET against the data-memory
// port, owns ESP and raises EIP redirects for CALL/RET.
module stack_op_sequencer
  import cpu_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter logic [DATA_W-1:0] STACK_TOP   = 32'h0000_1000,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  input  logic [DATA_W-1:0] ret_eip,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] esp,
  output logic [3:0]        sel_code,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              eip_load,
  output logic [DATA_W-1:0] eip_target,
  output logic              stack_fault
);

  localparam logic [DATA_W-1:0] STEP  = DATA_W'(WORD_BYTES);
  localparam logic [DATA_W:0]   STEPX = (DATA_W+1)'(WORD_BYTES);

  state_t            state_reg, state_next;
  logic [3:0]        op_code_reg;
  logic [DATA_W-1:0] op_data_reg;
  logic [DATA_W-1:0] ret_eip_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] esp_reg;
  logic              fault_reg;

  logic              accept;
  logic              start_write;
  logic              start_read;
  logic              fault_next;

  // Bounds are evaluated one bit wider so esp near zero or near the top of
  // the address space cannot wrap into a false pass.
  function automatic logic room_for(input logic [DATA_W-1:0] sp, input logic grow);
    logic [DATA_W:0] spx;
    spx = {1'b0, sp};
    if (grow)
      room_for = (spx >= ({1'b0, STACK_LIMIT} + STEPX));
    else
      room_for = ((spx + STEPX) <= {1'b0, STACK_TOP});
  endfunction

  assign accept = (state_reg == ST_IDLE) && op_valid;

  always_comb begin
    start_write = 1'b0;
    start_read  = 1'b0;
    fault_next  = 1'b0;
    if (accept) begin
      case (op_code)
        OP_PUSH, OP_CALL: begin
          if (room_for(esp_reg, 1'b1)) start_write = 1'b1;
          else                         fault_next  = 1'b1;
        end
        OP_POP, OP_RET: begin
          if (room_for(esp_reg, 1'b0)) start_read = 1'b1;
          else                         fault_next = 1'b1;
        end
        default: fault_next = 1'b1;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_write)     state_next = ST_WRITE;
        else if (start_read) state_next = ST_READ;
      end
      ST_WRITE: if (mem_ack) state_next = (op_code_reg == OP_CALL) ? ST_RESP : ST_IDLE;
      ST_READ:  if (mem_ack) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath: latched operands, captured read data, ESP and the fault pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_code_reg <= SEL_NONE;
      op_data_reg <= '0;
      ret_eip_reg <= '0;
      rdata_reg   <= '0;
      esp_reg     <= STACK_TOP;
      fault_reg   <= 1'b0;
    end else begin
      fault_reg <= fault_next;
      if (accept) begin
        op_code_reg <= op_code;
        op_data_reg <= op_data;
        ret_eip_reg <= ret_eip;
      end
      if (start_write)
        esp_reg <= esp_reg - STEP;
      if ((state_reg == ST_READ) && mem_ack) begin
        rdata_reg <= mem_rdata;
        esp_reg   <= esp_reg + STEP;
      end
    end
  end

  // Outputs
  always_comb begin
    op_ready    = (state_reg == ST_IDLE);
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sel_code    = SEL_NONE;
    pop_valid   = 1'b0;
    pop_data    = '0;
    eip_load    = 1'b0;
    eip_target  = '0;
    stack_fault = fault_reg;
    esp         = esp_reg;
    if (state_reg != ST_IDLE) sel_code = op_code_reg;
    case (state_reg)
      ST_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = esp_reg;
        mem_wdata = (op_code_reg == OP_CALL) ? ret_eip_reg : op_data_reg;
      end
      ST_READ: begin
        mem_req  = 1'b1;
        mem_addr = esp_reg;
      end
      ST_RESP: begin
        if (op_code_reg == OP_POP) begin
          pop_valid = 1'b1;
          pop_data  = rdata_reg;
        end else begin
          eip_load   = 1'b1;
          eip_target = (op_code_reg == OP_CALL) ? op_data_reg : rdata_reg;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Multi-cycle controller that sequences stack operations (PUSH, POP, CALL, RET) against the shared data-memory port.
- Owns the architectural ESP register and drives the select code consumed by the register-output selector.
- Issues EIP redirects for CALL and RET.
- Sits between instruction decode (op handshake) and the memory bus (req/ack handshake).

Parameters:
- DATA_W, 32, width of data, addresses and ESP.
- STACK_TOP, 32'h0000_1000, ESP reset value; highest legal ESP (empty stack).
- STACK_LIMIT, 32'h0000_0800, lowest legal ESP (full stack).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  decode presents an operation.
- op_ready  out  1  sequencer accepts an operation; op accepted when op_valid && op_ready.
- op_code  in  4  4'h1 PUSH, 4'h2 POP, 4'h3 CALL, 4'h4 RET; other values are illegal.
- op_data  in  DATA_W  PUSH value, or CALL target.
- ret_eip  in  DATA_W  return address pushed by CALL.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  byte address (always the current ESP value).
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion; may be asserted in the same cycle mem_req first rises.
- esp  out  DATA_W  architectural stack pointer.
- sel_code  out  4  latched op_code during an operation, 4'h0 when idle; drives the selector.
- pop_valid  out  1  one-cycle pulse; pop_data valid.
- pop_data  out  DATA_W  value popped by POP.
- eip_load  out  1  one-cycle pulse; eip_target valid.
- eip_target  out  DATA_W  new EIP (CALL target, or return address for RET).
- stack_fault  out  1  one-cycle pulse on overflow, underflow or illegal op.

Behaviour:
- Reset values (asynchronous, on rst_n=0):
  - state=IDLE, esp=STACK_TOP, sel_code=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - pop_valid=0, pop_data=0, eip_load=0, eip_target=0, stack_fault=0.
  - Reset mid-operation abandons the operation immediately, including dropping mem_req. No partial ESP update is retained.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - op_ready=1; all pulses low after one cycle.
  - On accept, latch op_code, op_data and ret_eip.
  - PUSH/CALL:
    - If esp - 4 < STACK_LIMIT (unsigned): pulse stack_fault next cycle, ESP unchanged, stay IDLE.
    - Otherwise esp <= esp - 4 and go to WRITE.
  - POP/RET:
    - If esp + 4 > STACK_TOP (unsigned): fault as above.
    - Otherwise go to READ.
  - Illegal op_code: pulse stack_fault, stay IDLE; the op is consumed.
- WRITE:
  - op_ready=0, mem_req=1, mem_we=1, mem_addr=esp (already decremented).
  - mem_wdata = op_data for PUSH, ret_eip for CALL.
  - On mem_ack: deassert mem_req next cycle. PUSH goes to IDLE; CALL goes to RESP.
- READ:
  - mem_req=1, mem_we=0, mem_addr=esp.
  - On mem_ack: capture mem_rdata, esp <= esp + 4, go to RESP.
- RESP: one cycle, then IDLE.
  - POP: pop_valid=1, pop_data=captured value.
  - RET: eip_load=1, eip_target=captured value.
  - CALL: eip_load=1, eip_target=latched op_data.
- Latency with zero-wait memory (ack in the first req cycle), accept at cycle N:
  - PUSH: mem_req high in N+1 only; op_ready high again at N+2.
  - POP/CALL/RET: response pulse at N+2; op_ready high at N+3.
- Memory wait states: mem_req, mem_we, mem_addr and mem_wdata stay stable until ack. No timeout.
- ESP is always a multiple of 4; arithmetic is DATA_W-bit unsigned with no wrap (bounds checked before update).
- sel_code is valid from the cycle after accept until the cycle the state returns to IDLE.

Decomposition:
- Shared package (cpu_pkg):
  - op code constants OP_PUSH=4'h1, OP_POP=4'h2, OP_CALL=4'h3, OP_RET=4'h4, SEL_NONE=4'h0;
  - the state enum;
  - WORD_BYTES=4.
- No sub-module is needed; the bounds check is a single function inside the block.

Test Plan:
- Reset, then PUSH op_data=32'hDEAD_BEEF with zero-wait ack -> mem write to addr 32'h0FFC, wdata DEAD_BEEF; esp=32'h0FFC; op_ready back at N+2.
- PUSH 32'h1111, PUSH 32'h2222, POP, POP with 2-cycle ack delay -> pop_data 32'h2222 then 32'h1111; esp returns to 32'h1000; request signals stable during the wait.
- CALL op_data=32'h0000_0400, ret_eip=32'h0000_0124, then RET:
  - CALL writes 0124 to 0FFC and pulses eip_load with 0400;
  - RET pulses eip_load with 0124; esp=1000.
- POP on an empty stack (esp=1000) -> stack_fault pulse, no mem_req, esp unchanged. PUSH with esp=32'h0800 -> stack_fault, esp stays 0800. op_code=4'h7 -> stack_fault.
- Assert rst_n=0 while in READ with mem_req high -> mem_req drops asynchronously, esp=32'h1000, state IDLE, op_ready=1 after release.
